// File: rtl/shift_add_mul_if.sv
// Handshake and external-adder bundle for the shift-add multiplier.
// The master side issues jobs and supplies the adder result; the slave side is the multiplier.
interface shift_add_mul_if #(
    parameter int W = 32
);
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    modport master (
        output start, a, b, add_sum, add_cout,
        input  busy, done, product, add_a, add_b
    );

    modport slave (
        input  start, a, b, add_sum, add_cout,
        output busy, done, product, add_a, add_b
    );
endinterface

// File: rtl/shift_add_mul.sv
// Sequential unsigned W x W multiplier: one shift-add iteration per clock,
// using an external W-bit adder for the partial-sum accumulation.
module shift_add_mul #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_add_mul_if.slave bus
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   m_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] product_q;
    logic           busy_q;
    logic           done_q;

    logic [2*W-1:0] acc_d;
    logic [CW-1:0]  cnt_d;
    logic           last_iter;

    // Adder operands are only live in RUN so the external adder sees 0 otherwise.
    always_comb begin
        bus.add_a = '0;
        bus.add_b = '0;
        if (state_q == RUN) begin
            bus.add_a = hi_q;
            if (lo_q[0]) begin
                bus.add_b = m_q;
            end
        end
    end

    // Carry-out becomes the new MSB, so the shift never loses the top bit of the sum.
    assign acc_d     = {bus.add_cout, bus.add_sum, lo_q[W-1:1]};
    assign cnt_d     = cnt_q + CW'(1);
    assign last_iter = (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= bus.a;
                        hi_q    <= '0;
                        lo_q    <= bus.b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    {hi_q, lo_q} <= acc_d;
                    cnt_q        <= cnt_d;
                    if (last_iter) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: table of operand/product vectors plus
// hand-written sequences for ignored starts and mid-run reset.
module tb_shift_add_mul;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        bit             b_zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [2*W-1:0] prev_p;
    vec_t vecs[8];

    shift_add_mul_if #(.W(W)) bus ();

    shift_add_mul #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Behavioural external adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one job; inject=1 re-asserts start (a=3,b=3) mid-RUN and in the DONE cycle.
    task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2*W-1:0] exp,
                           input bit b_zero, input bit inject, input string name);
        int done_cnt;
        int done_at;
        int busy_cnt;
        bit nz_b;
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        nz_b     = 1'b0;
        bus.a     = ta;
        bus.b     = tb_;
        bus.start = 1'b1;
        for (int c = 0; c < W + 3; c++) begin
            @(posedge clk);
            #1;
            if (inject && (c == 10 || c == W)) begin
                bus.start = 1'b1;
                bus.a     = 3;
                bus.b     = 3;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 0) chk({name, "_prod_hold_at_start"}, bus.product, prev_p);
            if (c == W) chk({name, "_adders_zero_done"}, {bus.add_a, bus.add_b}, '0);
            if (bus.done) begin
                done_cnt++;
                done_at = c;
            end
            if (bus.busy) busy_cnt++;
            if (bus.add_b != '0) nz_b = 1'b1;
        end
        chk({name, "_product"}, bus.product, exp);
        chk({name, "_done_edge"}, 64'(done_at), 64'(W));
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        chk({name, "_idle_adders"}, {bus.add_a, bus.add_b}, '0);
        if (b_zero) chk({name, "_add_b_zero"}, 64'(nz_b), 64'd0);
        prev_p = exp;
    endtask

    initial begin
        int dcount;
        checks    = 0;
        failures  = 0;
        prev_p    = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{a: 32'd7,          b: 32'd6,          p: 64'd42,                  b_zero: 1'b0};
        vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   p: 64'hFFFFFFFE00000001,    b_zero: 1'b0};
        vecs[2] = '{a: 32'h80000000,   b: 32'd2,          p: 64'h0000000100000000,    b_zero: 1'b0};
        vecs[3] = '{a: 32'd0,          b: 32'hFFFFFFFF,   p: 64'd0,                   b_zero: 1'b1};
        vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'd1,          p: 64'h00000000FFFFFFFF,    b_zero: 1'b0};
        vecs[5] = '{a: 32'h00010000,   b: 32'h00010000,   p: 64'h0000000100000000,    b_zero: 1'b0};
        vecs[6] = '{a: 32'd3,          b: 32'hFFFFFFFF,   p: 64'h00000002FFFFFFFD,    b_zero: 1'b0};
        vecs[7] = '{a: 32'hFFFFFFFF,   b: 32'd2,          p: 64'h00000001FFFFFFFE,    b_zero: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_product", bus.product, 64'd0);
        chk("reset_adders", {bus.add_a, bus.add_b}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].b_zero, 1'b0, $sformatf("vec%0d", i));
        end

        // Starts during RUN and DONE are dropped, next IDLE start is taken.
        run_job(32'd7, 32'd6, 64'd42, 1'b0, 1'b1, "ignore_start");
        run_job(32'd3, 32'd3, 64'd9, 1'b0, 1'b0, "after_ignore");

        // Asynchronous reset in the middle of RUN.
        bus.a     = 32'd7;
        bus.b     = 32'd6;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_product", bus.product, 64'd0);
        chk("midrst_adders", {bus.add_a, bus.add_b}, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dcount++;
        end
        chk("midrst_no_activity", 64'(dcount), 64'd0);
        prev_p = '0;
        run_job(32'd5, 32'd5, 64'd25, 1'b0, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
